// File: rtl/smg_scan_driver_if.sv
// smg_scan_driver_if: value/mask inputs and segment/select outputs
// of the multiplexed 7-segment scan driver.
interface smg_scan_driver_if #(
   parameter int DIGITS = 6
);
   logic                  enable;
   logic                  load;
   logic [4*DIGITS-1:0]   number_data;
   logic [DIGITS-1:0]     dp_mask;
   logic [DIGITS-1:0]     blank_mask;
   logic [7:0]            smg_data;
   logic [DIGITS-1:0]     smg_sel;
   logic                  frame_done;

   modport master (
      output enable, load, number_data, dp_mask, blank_mask,
      input  smg_data, smg_sel, frame_done
   );

   modport slave (
      input  enable, load, number_data, dp_mask, blank_mask,
      output smg_data, smg_sel, frame_done
   );
endinterface

// File: rtl/smg_scan_driver.sv
// smg_scan_driver: double-buffered multiplexed 7-segment scanner
// with guard interval and leading-zero blanking.
module smg_scan_driver #(
   parameter int DIGITS         = 6,
   parameter int SCAN_DIV       = 50000,
   parameter int GUARD          = 2,
   parameter bit ACTIVE_LOW_SEG = 1'b1,
   parameter bit ACTIVE_LOW_SEL = 1'b1,
   parameter bit BLANK_LEAD     = 1'b1
) (
   input logic               CLK,
   input logic               RST,
   smg_scan_driver_if.slave  bus
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int NW = 4 * DIGITS;

   localparam logic [7:0] SEG_OFF =
      ACTIVE_LOW_SEG ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] SEL_OFF =
      ACTIVE_LOW_SEL ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_GRD  = CW'(GUARD);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic              pending;
   logic [NW-1:0]     sh_num;
   logic [DIGITS-1:0] sh_dp;
   logic [DIGITS-1:0] sh_blk;
   logic [NW-1:0]     act_num;
   logic [DIGITS-1:0] act_dp;
   logic [DIGITS-1:0] act_blk;

   logic              tc;
   logic              boundary;
   logic [7:0]        seg_next;
   logic [DIGITS-1:0] sel_next;

   logic [7:0]        data_q;
   logic [DIGITS-1:0] sel_q;
   logic              done_q;

   function automatic logic [7:0] seg_code(input logic [3:0] n);
      case (n)
         4'h0: seg_code = 8'h3F;
         4'h1: seg_code = 8'h06;
         4'h2: seg_code = 8'h5B;
         4'h3: seg_code = 8'h4F;
         4'h4: seg_code = 8'h66;
         4'h5: seg_code = 8'h6D;
         4'h6: seg_code = 8'h7D;
         4'h7: seg_code = 8'h07;
         4'h8: seg_code = 8'h7F;
         4'h9: seg_code = 8'h6F;
         4'hA: seg_code = 8'h77;
         4'hB: seg_code = 8'h7C;
         4'hC: seg_code = 8'h39;
         4'hD: seg_code = 8'h5E;
         4'hE: seg_code = 8'h79;
         4'hF: seg_code = 8'h71;
      endcase
   endfunction

   assign tc       = (cnt == CNT_LAST);
   assign boundary = bus.enable && tc && (idx == IDX_LAST);

   // Segment image and select pattern for the current slot
   always_comb begin
      logic [3:0] nib;
      logic       hi_zero;
      logic [7:0] img;
      logic [DIGITS-1:0] hot;
      nib     = act_num[{idx, 2'b00} +: 4];
      hi_zero = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
         if (j >= int'(idx) && act_num[4*j +: 4] != 4'h0)
            hi_zero = 1'b0;
      end
      img = seg_code(nib);
      if (BLANK_LEAD && idx != '0 && hi_zero)
         img = 8'h00;
      img[7] = act_dp[idx];
      if (act_blk[idx])
         img = 8'h00;
      seg_next = ACTIVE_LOW_SEG ? ~img : img;
      hot      = '0;
      hot[idx] = 1'b1;
      if (cnt < CNT_GRD)
         hot = '0;
      sel_next = hot ^ SEL_OFF;
   end

   // Slot divider and digit index; parked at zero while disabled
   always_ff @(posedge CLK) begin
      if (RST || !bus.enable) begin
         cnt <= '0;
         idx <= '0;
      end else if (tc) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shadow/active buffers; active only changes at frame edge or idle
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending <= 1'b0;
         sh_num  <= '0;
         sh_dp   <= '0;
         sh_blk  <= '0;
         act_num <= '0;
         act_dp  <= '0;
         act_blk <= '0;
      end else begin
         if (boundary && bus.load) begin
            act_num <= bus.number_data;
            act_dp  <= bus.dp_mask;
            act_blk <= bus.blank_mask;
         end else if ((boundary || !bus.enable) && pending) begin
            act_num <= sh_num;
            act_dp  <= sh_dp;
            act_blk <= sh_blk;
         end
         if (bus.load) begin
            sh_num  <= bus.number_data;
            sh_dp   <= bus.dp_mask;
            sh_blk  <= bus.blank_mask;
            pending <= !boundary;
         end else if (boundary || !bus.enable) begin
            pending <= 1'b0;
         end
      end
   end

   // Registered pin drivers and frame pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         data_q <= SEG_OFF;
         sel_q  <= SEL_OFF;
         done_q <= 1'b0;
      end else begin
         done_q <= boundary;
         if (bus.enable) begin
            data_q <= seg_next;
            sel_q  <= sel_next;
         end else begin
            data_q <= SEG_OFF;
            sel_q  <= SEL_OFF;
         end
      end
   end

   assign bus.smg_data   = data_q;
   assign bus.smg_sel    = sel_q;
   assign bus.frame_done = done_q;
endmodule

// File: tb/tb_smg_scan_driver.sv
// tb_smg_scan_driver: directed plus random stimulus against a
// frame-position reference model of the scan driver.
module tb_smg_scan_driver;
   localparam int D     = 4;
   localparam int DIV   = 8;
   localparam int G     = 2;
   localparam int FRAME = D * DIV;

   logic clk = 1'b0;
   logic rst;

   smg_scan_driver_if #(.DIGITS(D)) bus ();

   smg_scan_driver #(
      .DIGITS(D), .SCAN_DIV(DIV), .GUARD(G),
      .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_SEL(1'b1),
      .BLANK_LEAD(1'b1)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   byte unsigned seg_tab [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   // model: frame position, buffers, expected registered outputs
   int         m_p;
   logic [15:0] m_an, m_sn;
   logic [3:0]  m_ad, m_ab, m_sd, m_sb;
   logic        m_pend;
   logic [7:0]  e_data;
   logic [3:0]  e_sel;
   logic        e_fd;
   int          last_p;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h",
                  tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] image(input int d);
      logic [7:0]  s;
      logic [15:0] hi;
      hi = m_an >> (4 * d);
      s  = seg_tab[hi[3:0]];
      if (d > 0 && hi == 16'h0) s = 8'h00;
      if (m_ad[d]) s = s | 8'h80;
      if (m_ab[d]) s = 8'h00;
      return ~s;
   endfunction

   task automatic tick();
      logic bnd;
      if (rst) begin
         m_p = 0; m_pend = 1'b0;
         m_an = '0; m_ad = '0; m_ab = '0;
         m_sn = '0; m_sd = '0; m_sb = '0;
         e_data = 8'hFF; e_sel = 4'hF; e_fd = 1'b0;
         last_p = -1;
      end else begin
         last_p = bus.enable ? m_p : -1;
         bnd    = bus.enable && (m_p == FRAME - 1);
         e_fd   = bnd;
         if (bus.enable) begin
            e_data = image(m_p / DIV);
            e_sel  = (m_p % DIV >= G)
                     ? ~(4'(1) << (m_p / DIV)) : 4'hF;
         end else begin
            e_data = 8'hFF;
            e_sel  = 4'hF;
         end
         if (bnd && bus.load) begin
            m_an = bus.number_data; m_ad = bus.dp_mask;
            m_ab = bus.blank_mask;
         end else if ((bnd || !bus.enable) && m_pend) begin
            m_an = m_sn; m_ad = m_sd; m_ab = m_sb;
         end
         if (bnd || !bus.enable) m_pend = 1'b0;
         if (bus.load) begin
            m_sn = bus.number_data; m_sd = bus.dp_mask;
            m_sb = bus.blank_mask;
            if (!bnd) m_pend = 1'b1;
         end
         m_p = bus.enable ? (m_p + 1) % FRAME : 0;
      end
      @(posedge clk);
      #1;
      chk("smg_data", bus.smg_data, e_data);
      chk("smg_sel", bus.smg_sel, e_sel);
      chk("frame_done", bus.frame_done, e_fd);
   endtask

   task automatic do_load(input logic [15:0] n, input logic [3:0] dp,
                          input logic [3:0] bl);
      bus.load = 1'b1;
      bus.number_data = n;
      bus.dp_mask = dp;
      bus.blank_mask = bl;
      tick();
      bus.load = 1'b0;
   endtask

   task automatic run_until(input int target);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (last_p != target && k < 4 * FRAME);
      if (last_p != target) chk("run_until", last_p, target);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      bus.enable = 1'b1;
      bus.load = 1'b0;
      bus.number_data = '0;
      bus.dp_mask = '0;
      bus.blank_mask = '0;

      // reset and idle
      repeat (3) tick();
      chk("rst_data", bus.smg_data, 8'hFF);
      chk("rst_sel", bus.smg_sel, 4'hF);
      chk("rst_fd", bus.frame_done, 1'b0);
      rst = 1'b0;
      run_until(4);
      chk("idle_d0", bus.smg_data, 8'hC0);
      chk("idle_s0", bus.smg_sel, 4'hE);
      run_until(12);
      chk("idle_d1", bus.smg_data, 8'hFF);
      chk("idle_s1", bus.smg_sel, 4'hD);

      // basic scan
      do_load(16'h1234, 4'h0, 4'h0);
      run_until(4);
      chk("scan_d0", bus.smg_data, 8'h99);
      chk("scan_s0", bus.smg_sel, 4'hE);
      run_until(1);
      chk("scan_guard", bus.smg_sel, 4'hF);
      run_until(28);
      chk("scan_d3", bus.smg_data, 8'hF9);
      chk("scan_s3", bus.smg_sel, 4'h7);
      k = 0;
      do begin tick(); k++; end
      while (!bus.frame_done && k < 2 * FRAME);
      k = 0;
      do begin tick(); k++; end
      while (!bus.frame_done && k < 2 * FRAME);
      chk("fd_period", k, FRAME);

      // leading zeros
      do_load(16'h0070, 4'h0, 4'h0);
      run_until(FRAME - 1);
      run_until(4);  chk("lz_d0", bus.smg_data, 8'hC0);
      run_until(12); chk("lz_d1", bus.smg_data, 8'hF8);
      run_until(20); chk("lz_d2", bus.smg_data, 8'hFF);
      run_until(28); chk("lz_d3", bus.smg_data, 8'hFF);
      do_load(16'h0000, 4'b0100, 4'h0);
      run_until(FRAME - 1);
      run_until(4);  chk("lzdp_d0", bus.smg_data, 8'hC0);
      run_until(12); chk("lzdp_d1", bus.smg_data, 8'hFF);
      run_until(20); chk("lzdp_d2", bus.smg_data, 8'h7F);
      run_until(28); chk("lzdp_d3", bus.smg_data, 8'hFF);

      // double buffering
      run_until(10);
      do_load(16'h1111, 4'h0, 4'h0);
      tick();
      do_load(16'h2222, 4'h0, 4'h0);
      run_until(20); chk("db_hold", bus.smg_data, 8'h7F);
      run_until(4);  chk("db_d0", bus.smg_data, 8'hA4);
      run_until(28); chk("db_d3", bus.smg_data, 8'hA4);
      run_until(FRAME - 2);
      do_load(16'h3333, 4'h0, 4'h0);
      run_until(4);  chk("bnd_load", bus.smg_data, 8'hB0);

      // blank mask override
      do_load(16'h8888, 4'hF, 4'b0010);
      run_until(FRAME - 1);
      run_until(4);  chk("bl_d0", bus.smg_data, 8'h00);
      run_until(12); chk("bl_d1", bus.smg_data, 8'hFF);
      run_until(20); chk("bl_d2", bus.smg_data, 8'h00);

      // reset and enable mid-operation
      do_load(16'h5555, 4'h0, 4'h0);
      run_until(20);
      rst = 1'b1;
      tick();
      chk("mrst_data", bus.smg_data, 8'hFF);
      chk("mrst_sel", bus.smg_sel, 4'hF);
      rst = 1'b0;
      run_until(4);  chk("mrst_d0", bus.smg_data, 8'hC0);
      run_until(12);
      bus.enable = 1'b0;
      tick();
      chk("dis_sel", bus.smg_sel, 4'hF);
      chk("dis_data", bus.smg_data, 8'hFF);
      repeat (5) tick();
      bus.enable = 1'b1;
      repeat (3) tick();
      chk("reen_sel", bus.smg_sel, 4'hE);
      chk("reen_data", bus.smg_data, 8'hC0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
         bus.load = ($urandom_range(0, 15) == 0);
         bus.number_data = 16'($urandom) &
                           (16'hFFFF >> (4 * $urandom_range(0, 4)));
         bus.dp_mask = 4'($urandom);
         bus.blank_mask = ($urandom_range(0, 3) == 0)
                          ? 4'($urandom) : 4'h0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
